// File: rtl/neuron_layer_seq_if.sv
// Stream, weight-write and neuron-port bundle for the layer sequencer.
interface neuron_layer_seq_if #(
  parameter int unsigned NNEURONS = 4
);
  localparam int unsigned IW = $clog2(NNEURONS);

  // activation input stream
  logic signed [7:0]  in_data;
  logic               in_valid;
  logic               in_ready;

  // weight/bias register-file write port
  logic               wr_en;
  logic [IW-1:0]      wr_addr;
  logic [2:0]         wr_sel;
  logic [15:0]        wr_data;
  logic               wr_ready;

  // combinational neuron connection
  logic signed [7:0]  n_X1, n_X2, n_X3, n_X4;
  logic signed [7:0]  n_W1, n_W2, n_W3, n_W4;
  logic signed [15:0] n_bias;
  logic signed [11:0] n_xmin;
  logic signed [11:0] n_xmax;
  logic signed [7:0]  n_y;

  // result output stream
  logic signed [7:0]  out_data;
  logic               out_valid;
  logic               out_ready;
  logic [IW-1:0]      out_idx;
  logic               layer_done;

  modport slave (
    input  in_data, in_valid, wr_en, wr_addr, wr_sel, wr_data, n_y, out_ready,
    output in_ready, wr_ready,
    output n_X1, n_X2, n_X3, n_X4, n_W1, n_W2, n_W3, n_W4, n_bias, n_xmin, n_xmax,
    output out_data, out_valid, out_idx, layer_done
  );

  modport master (
    output in_data, in_valid, wr_en, wr_addr, wr_sel, wr_data, n_y, out_ready,
    input  in_ready, wr_ready,
    input  n_X1, n_X2, n_X3, n_X4, n_W1, n_W2, n_W3, n_W4, n_bias, n_xmin, n_xmax,
    input  out_data, out_valid, out_idx, layer_done
  );
endinterface

// File: rtl/neuron_layer_seq.sv
// Time-multiplexes one combinational neuron across NNEURONS weight sets:
// gathers a 4-element activation vector, runs each neuron for one cycle and
// streams the captured results out with valid/ready.
module neuron_layer_seq #(
  parameter int unsigned NNEURONS = 4,
  parameter int          XMIN     = -127,
  parameter int          XMAX     = 127
) (
  input  logic              clk,
  input  logic              rst_n,
  neuron_layer_seq_if.slave bus
);
  localparam int unsigned IW   = $clog2(NNEURONS);
  localparam logic [IW-1:0] LAST = IW'(NNEURONS - 1);

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_RUN     = 2'd1,
    S_WAIT    = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [1:0]         r_cnt;
  logic [IW-1:0]      r_idx;
  logic signed [7:0]  r_x [4];
  logic signed [7:0]  r_w [NNEURONS][4];
  logic signed [15:0] r_b [NNEURONS];
  logic signed [7:0]  r_nx [4];
  logic signed [7:0]  r_nw [4];
  logic signed [15:0] r_nbias;
  logic signed [7:0]  r_out_data;
  logic               r_out_valid;
  logic [IW-1:0]      r_out_idx;
  logic               r_layer_done;

  logic               w_in_ready;
  logic               w_wr_ready;
  logic               w_in_acc;
  logic               w_wr_acc;
  logic               w_start;
  logic               w_out_hs;
  logic               w_last;
  logic [IW-1:0]      w_idx_nxt;

  assign w_in_acc  = bus.in_valid & w_in_ready;
  assign w_wr_acc  = bus.wr_en & w_wr_ready & (32'(bus.wr_addr) < NNEURONS);
  assign w_start   = (r_state == S_COLLECT) & w_in_acc & (r_cnt == 2'd3);
  assign w_out_hs  = (r_state == S_WAIT) & bus.out_ready;
  assign w_last    = (r_idx == LAST);
  assign w_idx_nxt = r_idx + IW'(1);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_COLLECT;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_COLLECT: if (w_start) w_state_nxt = S_RUN;
      S_RUN:     w_state_nxt = S_WAIT;
      S_WAIT:    if (bus.out_ready) w_state_nxt = w_last ? S_COLLECT : S_RUN;
      default:   w_state_nxt = S_COLLECT;
    endcase
  end

  // Handshake readies decoded from state; writes only between layers
  always_comb begin
    w_in_ready = 1'b0;
    w_wr_ready = 1'b0;
    if (r_state == S_COLLECT) begin
      w_in_ready = 1'b1;
      w_wr_ready = (r_cnt == 2'd0);
    end
  end

  // Activation capture and neuron index sequencing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 2'd0;
      r_idx <= '0;
      for (int i = 0; i < 4; i++) r_x[i] <= '0;
    end else begin
      if ((r_state == S_COLLECT) && w_in_acc) begin
        r_x[r_cnt] <= bus.in_data;
        r_cnt      <= r_cnt + 2'd1;
      end
      if (w_start) r_idx <= '0;
      else if (w_out_hs && !w_last) r_idx <= w_idx_nxt;
    end
  end

  // Weight/bias register file; weights keep only the low byte
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < NNEURONS; n++) begin
        r_b[n] <= '0;
        for (int k = 0; k < 4; k++) r_w[n][k] <= '0;
      end
    end else if (w_wr_acc) begin
      case (bus.wr_sel)
        3'd0, 3'd1, 3'd2, 3'd3: r_w[bus.wr_addr][bus.wr_sel[1:0]] <= bus.wr_data[7:0];
        3'd4:                   r_b[bus.wr_addr] <= bus.wr_data;
        default: ;
      endcase
    end
  end

  // Neuron port drive, loaded on entry to each RUN cycle and held otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin
        r_nx[k] <= '0;
        r_nw[k] <= '0;
      end
      r_nbias <= '0;
    end else if (w_start) begin
      r_nx[0] <= r_x[0];
      r_nx[1] <= r_x[1];
      r_nx[2] <= r_x[2];
      r_nx[3] <= bus.in_data;
      for (int k = 0; k < 4; k++) r_nw[k] <= r_w[0][k];
      r_nbias <= r_b[0];
    end else if (w_out_hs && !w_last) begin
      for (int k = 0; k < 4; k++) r_nw[k] <= r_w[w_idx_nxt][k];
      r_nbias <= r_b[w_idx_nxt];
    end
  end

  // Result capture and output stream
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data   <= '0;
      r_out_valid  <= 1'b0;
      r_out_idx    <= '0;
      r_layer_done <= 1'b0;
    end else begin
      r_layer_done <= w_out_hs & w_last;
      if (r_state == S_RUN) begin
        r_out_data  <= bus.n_y;
        r_out_idx   <= r_idx;
        r_out_valid <= 1'b1;
      end else if (w_out_hs) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.wr_ready   = w_wr_ready;
  assign bus.n_X1       = r_nx[0];
  assign bus.n_X2       = r_nx[1];
  assign bus.n_X3       = r_nx[2];
  assign bus.n_X4       = r_nx[3];
  assign bus.n_W1       = r_nw[0];
  assign bus.n_W2       = r_nw[1];
  assign bus.n_W3       = r_nw[2];
  assign bus.n_W4       = r_nw[3];
  assign bus.n_bias     = r_nbias;
  assign bus.n_xmin     = 12'(XMIN);
  assign bus.n_xmax     = 12'(XMAX);
  assign bus.out_data   = r_out_data;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_idx    = r_out_idx;
  assign bus.layer_done = r_layer_done;
endmodule

// File: tb/tb_neuron_layer_seq.sv
// Bench for the layer sequencer: a combinational neuron stub closes the loop
// and results are checked against an arithmetic layer model.
module tb_neuron_layer_seq;
  localparam int unsigned N  = 4;
  localparam int unsigned IW = $clog2(N);

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;

  // layer model: weights and biases as plain integers
  int mw [N][4];
  int mb [N];

  always #5 clk = ~clk;

  neuron_layer_seq_if #(.NNEURONS(N)) bus ();

  neuron_layer_seq #(.NNEURONS(N), .XMIN(-127), .XMAX(127)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // neuron stub: Y = (X.W + bias) truncated to 8 bits
  assign bus.n_y = 8'(int'(bus.n_X1) * int'(bus.n_W1) + int'(bus.n_X2) * int'(bus.n_W2) +
                      int'(bus.n_X3) * int'(bus.n_W3) + int'(bus.n_X4) * int'(bus.n_W4) +
                      int'(bus.n_bias));

  function automatic logic signed [7:0] ref_y(input int n, input int x[4]);
    int s;
    s = mb[n];
    for (int k = 0; k < 4; k++) s += x[k] * mw[n][k];
    return 8'(s);
  endfunction

  task automatic clear_model();
    for (int n = 0; n < N; n++) begin
      mb[n] = 0;
      for (int k = 0; k < 4; k++) mw[n][k] = 0;
    end
  endtask

  // one write cycle starting at a falling edge; take says whether it should land
  task automatic do_write(input int addr, input int sel, input logic [15:0] data, input bit take);
    logic signed [7:0] wb;
    bus.wr_en   = 1'b1;
    bus.wr_addr = IW'(addr);
    bus.wr_sel  = 3'(sel);
    bus.wr_data = data;
    if (take && sel <= 3) begin
      wb = data[7:0];
      mw[addr][sel] = int'(wb);
    end else if (take && sel == 4) begin
      mb[addr] = int'($signed(data));
    end
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  task automatic send_act(input int a);
    int c = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'(a);
    while (!bus.in_ready && c < 100) begin
      @(negedge clk);
      c++;
    end
    if (c >= 100) begin
      n_vec++;
      n_err++;
      $display("FAIL send_act timeout: in_ready stayed %b, required 1", bus.in_ready);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic send_vec(input int x[4]);
    for (int k = 0; k < 4; k++) send_act(x[k]);
  endtask

  // drain results from neuron 'first' onward and check the layer_done pulse
  task automatic collect(input int x[4], input bit rnd, input int first);
    int k = first;
    int cyc = 0;
    logic signed [7:0] e;
    while (k < N && cyc < 500) begin
      bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bus.out_valid && bus.out_ready) begin
        e = ref_y(k, x);
        n_vec++;
        if (bus.out_data !== e) begin
          n_err++;
          $display("FAIL collect data n%0d: got %0d, required %0d", k, bus.out_data, e);
        end
        n_vec++;
        if (bus.out_idx !== IW'(k)) begin
          n_err++;
          $display("FAIL collect idx: got %0d, required %0d", bus.out_idx, k);
        end
        k++;
      end
      @(negedge clk);
      cyc++;
    end
    n_vec++;
    if (k < N) begin
      n_err++;
      $display("FAIL collect timeout: got %0d results, required %0d", k, N);
    end else if (bus.layer_done !== 1'b1) begin
      n_err++;
      $display("FAIL collect layer_done: got %b, required 1", bus.layer_done);
    end
    bus.out_ready = 1'b1;
  endtask

  task automatic test_reset();
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.wr_en     = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_sel    = '0;
    bus.wr_data   = '0;
    bus.out_ready = 1'b1;
    clear_model();
    rst_n = 1'b0;
    #12;
    n_vec++; if (bus.in_ready !== 1'b1)  begin n_err++; $display("FAIL reset in_ready: got %b, required 1", bus.in_ready); end
    n_vec++; if (bus.wr_ready !== 1'b1)  begin n_err++; $display("FAIL reset wr_ready: got %b, required 1", bus.wr_ready); end
    n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset out_valid: got %b, required 0", bus.out_valid); end
    n_vec++; if (bus.out_data !== 8'sd0) begin n_err++; $display("FAIL reset out_data: got %0d, required 0", bus.out_data); end
    n_vec++; if (bus.out_idx !== '0)     begin n_err++; $display("FAIL reset out_idx: got %0d, required 0", bus.out_idx); end
    n_vec++; if (bus.layer_done !== 1'b0) begin n_err++; $display("FAIL reset layer_done: got %b, required 0", bus.layer_done); end
    n_vec++; if (bus.n_W1 !== 8'sd0 || bus.n_X4 !== 8'sd0 || bus.n_bias !== 16'sd0) begin
      n_err++; $display("FAIL reset neuron ports: W1=%0d X4=%0d bias=%0d, required 0", bus.n_W1, bus.n_X4, bus.n_bias);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_full_layer();
    int x[4] = '{1, 2, 3, 4};
    for (int k = 0; k < N; k++) begin
      for (int s = 0; s < 4; s++) do_write(k, s, 16'(k + 1), 1'b1);
      do_write(k, 4, 16'(10 * k), 1'b1);
    end
    send_vec(x);
    n_vec++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
      n_err++; $display("FAIL full run-cycle: out_valid=%b in_ready=%b, required 0 0", bus.out_valid, bus.in_ready);
    end
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      n_vec++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL full valid n%0d: got %b, required 1", k, bus.out_valid); end
      n_vec++; if (bus.out_data !== 8'(10 + 20 * k)) begin
        n_err++; $display("FAIL full data n%0d: got %0d, required %0d", k, bus.out_data, 10 + 20 * k);
      end
      n_vec++; if (bus.out_idx !== IW'(k)) begin n_err++; $display("FAIL full idx: got %0d, required %0d", bus.out_idx, k); end
      @(negedge clk);
      if (k < N - 1) begin
        n_vec++; if (bus.out_valid !== 1'b0 || bus.layer_done !== 1'b0) begin
          n_err++; $display("FAIL full gap n%0d: valid=%b done=%b, required 0 0", k, bus.out_valid, bus.layer_done);
        end
      end else begin
        n_vec++; if (bus.layer_done !== 1'b1 || bus.in_ready !== 1'b1) begin
          n_err++; $display("FAIL full done: done=%b in_ready=%b, required 1 1", bus.layer_done, bus.in_ready);
        end
      end
    end
    @(negedge clk);
    n_vec++; if (bus.layer_done !== 1'b0) begin n_err++; $display("FAIL full done pulse width: got %b, required 0", bus.layer_done); end
  endtask

  task automatic test_backpressure();
    int x[4] = '{1, 2, 3, 4};
    send_vec(x);
    @(negedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      n_vec++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'sd30 || bus.out_idx !== IW'(1) || bus.in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL backpressure c%0d: valid=%b data=%0d idx=%0d in_ready=%b, required 1 30 1 0",
                 c, bus.out_valid, bus.out_data, bus.out_idx, bus.in_ready);
      end
      @(negedge clk);
    end
    collect(x, 1'b0, 1);
  endtask

  task automatic test_write_gating();
    int x[4]  = '{5, -3, 7, 2};
    int x2[4] = '{-9, 4, 1, 6};
    bus.out_ready = 1'b0;
    send_vec(x);
    @(negedge clk);
    n_vec++; if (bus.wr_ready !== 1'b0) begin n_err++; $display("FAIL gating wr_ready in WAIT: got %b, required 0", bus.wr_ready); end
    do_write(0, 4, 16'd99, 1'b0);
    collect(x, 1'b0, 0);
    send_act(x2[0]);
    send_act(x2[1]);
    n_vec++; if (bus.wr_ready !== 1'b0) begin n_err++; $display("FAIL gating wr_ready cnt2: got %b, required 0", bus.wr_ready); end
    do_write(0, 4, 16'd99, 1'b0);
    send_act(x2[2]);
    send_act(x2[3]);
    collect(x2, 1'b0, 0);
  endtask

  task automatic test_sign();
    int x[4] = '{-128, 0, 0, 0};
    do_write(0, 0, 16'hFF80, 1'b1);
    send_vec(x);
    n_vec++; if (bus.n_W1 !== -8'sd128 || bus.n_X1 !== -8'sd128) begin
      n_err++; $display("FAIL sign ports: W1=%0d X1=%0d, required -128 -128", bus.n_W1, bus.n_X1);
    end
    n_vec++; if (bus.n_xmin !== -12'sd127 || bus.n_xmax !== 12'sd127) begin
      n_err++; $display("FAIL sign xmin/xmax: got %0d %0d, required -127 127", bus.n_xmin, bus.n_xmax);
    end
    collect(x, 1'b0, 0);
  endtask

  task automatic test_back_to_back();
    int acts[8];
    int xa[4];
    int xb[4];
    logic signed [7:0] exp_q[$];
    int i = 0;
    int k = 0;
    int cyc = 0;
    int stalls = 0;
    for (int j = 0; j < 8; j++) acts[j] = int'($urandom_range(0, 255)) - 128;
    for (int j = 0; j < 4; j++) begin
      xa[j] = acts[j];
      xb[j] = acts[j + 4];
    end
    for (int n = 0; n < N; n++) exp_q.push_back(ref_y(n, xa));
    for (int n = 0; n < N; n++) exp_q.push_back(ref_y(n, xb));
    bus.out_ready = 1'b1;
    while ((i < 8 || k < 2 * N) && cyc < 500) begin
      if (i < 8) begin
        bus.in_valid = 1'b1;
        bus.in_data  = 8'(acts[i]);
      end else begin
        bus.in_valid = 1'b0;
      end
      if (bus.out_valid) begin
        n_vec++; if (bus.out_data !== exp_q[k] || bus.out_idx !== IW'(k % N)) begin
          n_err++; $display("FAIL b2b result %0d: got %0d idx %0d, required %0d idx %0d",
                            k, bus.out_data, bus.out_idx, exp_q[k], k % N);
        end
        k++;
      end
      if (i < 8 && bus.in_ready) begin
        if (i == 4) begin
          n_vec++; if (bus.layer_done !== 1'b1 || k != N) begin
            n_err++; $display("FAIL b2b 5th accept: layer_done=%b results=%0d, required 1 %0d", bus.layer_done, k, N);
          end
        end
        i++;
      end else if (i >= 4 && i < 8) begin
        stalls++;
      end
      @(negedge clk);
      cyc++;
    end
    bus.in_valid = 1'b0;
    n_vec++; if (i != 8 || k != 2 * N) begin
      n_err++; $display("FAIL b2b timeout: accepted %0d results %0d, required 8 %0d", i, k, 2 * N);
    end
    n_vec++; if (stalls < 2 * N - 1) begin
      n_err++; $display("FAIL b2b stall: got %0d stall cycles, required at least %0d", stalls, 2 * N - 1);
    end
  endtask

  task automatic test_random();
    int x[4];
    for (int l = 0; l < 4; l++) begin
      for (int w = 0; w < 8; w++)
        do_write(int'($urandom_range(0, N - 1)), int'($urandom_range(0, 7)), 16'($urandom), 1'b1);
      for (int j = 0; j < 4; j++) x[j] = int'($urandom_range(0, 255)) - 128;
      send_vec(x);
      collect(x, 1'b1, 0);
    end
  endtask

  task automatic test_reset_midop();
    int x[4] = '{3, 1, -4, 1};
    bus.out_ready = 1'b0;
    send_vec(x);
    @(negedge clk);
    n_vec++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL midreset setup valid: got %b, required 1", bus.out_valid); end
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.wr_ready !== 1'b1 || bus.layer_done !== 1'b0) begin
      n_err++; $display("FAIL midreset async: valid=%b in_ready=%b wr_ready=%b done=%b, required 0 1 1 0",
                        bus.out_valid, bus.in_ready, bus.wr_ready, bus.layer_done);
    end
    clear_model();
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    n_vec++; if (bus.n_W1 !== 8'sd0 || bus.n_W2 !== 8'sd0 || bus.n_W3 !== 8'sd0 || bus.n_W4 !== 8'sd0 || bus.n_bias !== 16'sd0) begin
      n_err++; $display("FAIL midreset weights: W=%0d %0d %0d %0d bias=%0d, required 0",
                        bus.n_W1, bus.n_W2, bus.n_W3, bus.n_W4, bus.n_bias);
    end
    x = '{100, -50, 25, 7};
    send_vec(x);
    collect(x, 1'b0, 0);
  endtask

  initial begin
    test_reset();
    test_full_layer();
    test_backpressure();
    test_write_gating();
    test_sign();
    test_back_to_back();
    test_random();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, required to finish");
    $fatal(1);
  end
endmodule
